fir_serial_mac: RTL and testbench
=================================

FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

Interface
REQ-001 SHALL have parameter NTAPS, default 16, number of filter taps (power of two, 4..64).
REQ-002 SHALL have parameter DW, default 16, signed two's-complement sample width in and out.
REQ-003 SHALL have parameter CW, default 16, signed Q1.(CW-1) coefficient width.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  a new sample is on in_data this cycle.
REQ-007 SHALL have port in_data  input  DW  signed sample, e.g. from the sine generator output.
REQ-008 SHALL have port in_ready  output  1  high only in IDLE; a sample is accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port coef_we  input  1  coefficient write strobe.
REQ-010 SHALL have port coef_addr  input  log2(NTAPS)  coefficient index k.
REQ-011 SHALL have port coef_data  input  CW  signed coefficient value.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse marking a new out_data.
REQ-013 SHALL have port out_data  output  DW  signed filtered sample; holds between pulses.
REQ-014 SHALL have port overrun  output  1  sticky; set when in_valid arrives with in_ready low.

Function
REQ-015 SHALL compute y[n] = sum over k=0..NTAPS-1 of c[k]*x[n-k], using one multiplier time-shared across taps.
REQ-016 SHALL store samples in an NTAPS-deep circular delay line; each accept writes at wr_ptr, and wr_ptr wraps modulo NTAPS.
REQ-017 SHALL use FSM states IDLE->MAC on accept, MAC->OUT after NTAPS tap cycles, and OUT->IDLE unconditionally.
REQ-018 SHALL, for an accept in cycle T, perform tap k in cycle T+1+k, assert out_valid in cycle T+NTAPS+1 (T+17 at default), and raise in_ready again at T+NTAPS+2.
REQ-019 SHALL use an accumulator of width DW+CW+log2(NTAPS) that cleared at the start of MAC, so no intermediate overflow occurs.
REQ-020 SHALL form out_data as the accumulator arithmetic-shifted right by CW-1, saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-021 SHALL drop any in_valid while in_ready=0, leave the delay line unchanged, and set overrun, which clears only on rst.
REQ-022 SHALL accept coef_we only while in_ready=1 and silently ignore it otherwise.
REQ-023 SHALL, when coef_we and an accept occur in the same IDLE cycle, use the newly written coefficient in that computation.
REQ-024 SHALL make a sample accepted in cycle T visible as x[n] in the computation it starts.

Reset
REQ-025 SHALL, on rst, force state IDLE, in_ready=1 in the following cycle, out_valid=0, out_data=0, overrun=0, wr_ptr=0, and accumulator=0.
REQ-026 SHALL, on rst, clear the delay line to 0 and set c[0]=2^(CW-1)-1 with all other coefficients 0 (near-unity pass-through).
REQ-027 SHALL, when rst occurs during MAC or OUT, abort the computation and produce no out_valid for it; rst has priority over all other inputs.

Configuration
REQ-028 SHALL add 2^(CW-2) to the accumulator before the REQ-020 shift when FIR_ROUND_EN is defined (round-half-up).
REQ-029 SHALL truncate (floor) in the REQ-020 shift when FIR_ROUND_EN is not defined; all other behaviour is identical.

Verification
REQ-030 SHALL cover: after reset, feed 0x4000 -> out_valid 17 cycles later with out_data 0x3FFF (truncating) or 0x4000 (FIR_ROUND_EN).
REQ-031 SHALL cover: load c[k]=0x0100*(k+1), feed 0x7FFF then 15 zeros -> outputs 0x0100*(n+1)-1 (truncating) or 0x0100*(n+1) (FIR_ROUND_EN), for n=0..15.
REQ-032 SHALL cover: all coefficients 0x7FFF and 16 samples of 0x7FFF -> 16th out_data 0x7FFF; 16 samples of 0x8000 -> 0x8000 (saturation).
REQ-033 SHALL cover: in_valid at T and T+3 -> one out_valid only, overrun=1 from T+4 until rst, delay line unchanged by the second sample.
REQ-034 SHALL cover: rst at T+5 after an accept -> no out_valid, in_ready=1 at T+6, out_data=0, coefficients back to reset values.
REQ-035 SHALL cover: coef_we c[0]=0 at T+2 during MAC -> ignored, so the next result still uses c[0]=0x7FFF.

Source files
------------

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: serial multiply-accumulate FIR filter.
// One multiplier is shared across all taps, so each accepted sample takes
// NTAPS MAC cycles plus one output cycle. Samples sit in a circular delay line.
// Define FIR_ROUND_EN to round the output half-up; without it the output is truncated (floor).
module fir_serial_mac #(
    parameter int NTAPS = 16,
    parameter int DW    = 16,
    parameter int CW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [DW-1:0]       in_data,
    output logic                       in_ready,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]       coef_data,
    output logic                       out_valid,
    output logic signed [DW-1:0]       out_data,
    output logic                       overrun
);

    localparam int AW   = $clog2(NTAPS);
    localparam int PW   = DW + CW;
    localparam int ACCW = DW + CW + AW;

    localparam logic signed [CW-1:0]   COEF_ONE = {1'b0, {(CW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MAX  = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN  = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic signed [DW-1:0]   delay_line [NTAPS];
    logic signed [CW-1:0]   coef       [NTAPS];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          tap_cnt;
    logic signed [ACCW-1:0] acc;
    logic signed [PW-1:0]   product;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] biased;
    logic signed [ACCW-1:0] shifted;
    logic signed [DW-1:0]   sat_data;
    logic                   accept;
    logic                   tap_last;

    assign accept   = in_valid && in_ready;
    assign tap_last = (tap_cnt == AW'(NTAPS - 1));

    // The shared multiplier: rd_ptr walks backwards from the newest sample while tap_cnt walks the coefficients.
    assign product  = PW'(delay_line[rd_ptr]) * PW'(coef[tap_cnt]);
    assign acc_next = acc + ACCW'(product);

`ifdef FIR_ROUND_EN
    localparam logic signed [ACCW-1:0] ROUND_BIAS = {{(ACCW-1){1'b0}}, 1'b1} << (CW - 2);
    assign biased = acc_next + ROUND_BIAS;
`else
    assign biased = acc_next;
`endif

    assign shifted  = biased >>> (CW - 1);
    assign sat_data = (shifted > SAT_MAX) ? SAT_MAX[DW-1:0] :
                      (shifted < SAT_MIN) ? SAT_MIN[DW-1:0] :
                      shifted[DW-1:0];

    // State register; reset aborts any computation in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and handshake outputs derived from the current state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MAC;
            end
            MAC: begin
                if (tap_last) state_next = OUT;
            end
            OUT: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Delay line and coefficient storage; both are only writable while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                delay_line[i] <= '0;
                coef[i]       <= (i == 0) ? COEF_ONE : '0;
            end
        end else begin
            if (in_ready && coef_we) coef[coef_addr] <= coef_data;
            if (accept)              delay_line[wr_ptr] <= in_data;
        end
    end

    // Pointers, tap counter, accumulator and the held output sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tap_cnt  <= '0;
            acc      <= '0;
            out_data <= '0;
        end else if (accept) begin
            rd_ptr  <= wr_ptr;
            wr_ptr  <= wr_ptr + AW'(1);
            tap_cnt <= '0;
            acc     <= '0;
        end else if (state == MAC) begin
            acc     <= acc_next;
            rd_ptr  <= rd_ptr - AW'(1);
            tap_cnt <= tap_cnt + AW'(1);
            if (tap_last) out_data <= sat_data;
        end
    end

    // Sticky flag for samples offered while the filter was busy.
    always_ff @(posedge clk) begin
        if (rst)                        overrun <= 1'b0;
        else if (in_valid && !in_ready) overrun <= 1'b1;
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: directed bench for fir_serial_mac at default parameters.
// Expected values are hand-computed; FIR_ROUND_EN adds one LSB where rounding differs.
module tb_fir_serial_mac;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        overrun;

`ifdef FIR_ROUND_EN
    localparam logic [15:0] RND = 16'd1;
`else
    localparam logic [15:0] RND = 16'd0;
`endif

    int check_count = 0;
    int pass_count  = 0;

    fir_serial_mac #(.NTAPS(16), .DW(16), .CW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .overrun   (overrun)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic writeCoef(input logic [3:0] addr, input logic [15:0] value);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = value;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Offers one sample (optionally writing c[0] in the same cycle) and waits for its result.
    task automatic applyStimulus(input logic [15:0] x, input logic with_coef, input logic [15:0] c0,
                                 output logic [15:0] y, output int latency);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid  = 1'b1;
        in_data   = x;
        coef_we   = with_coef;
        coef_addr = 4'd0;
        coef_data = c0;
        latency   = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            coef_we  = 1'b0;
            latency++;
        end while (!out_valid && latency < 100);
        y = out_data;
    endtask

    initial begin
        logic [15:0] y;
        int          lat;
        int          pulses;
        logic [15:0] last;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Single 0x4000 sample through near-unity c[0]
        applyStimulus(16'h4000, 1'b0, 16'h0, y, lat);
        checkOutput("unity_latency", 32'(lat), 32'd17);
        checkOutput("unity_data", 32'(y), 32'(16'h3FFF + RND));
        checkOutput("unity_busy_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("unity_pulse_end", 32'(out_valid), 32'd0);
        checkOutput("unity_ready_back", 32'(in_ready), 32'd1);
        checkOutput("unity_hold", 32'(out_data), 32'(16'h3FFF + RND));

        // Coefficient written in the accept cycle is used immediately
        applyStimulus(16'h4000, 1'b1, 16'h4000, y, lat);
        checkOutput("same_cycle_coef", 32'(y), 32'h2000);

        // Impulse through ramped coefficients
        doReset();
        for (int k = 0; k < 16; k++) writeCoef(4'(k), 16'(16'h0100 * (k + 1)));
        for (int n = 0; n < 16; n++) begin
            applyStimulus((n == 0) ? 16'h7FFF : 16'h0000, 1'b0, 16'h0, y, lat);
            checkOutput($sformatf("ramp_lat_%0d", n), 32'(lat), 32'd17);
            checkOutput($sformatf("ramp_data_%0d", n), 32'(y), 32'(16'(16'h0100 * (n + 1) - 1) + RND));
        end

        // Saturation at both rails
        doReset();
        for (int k = 0; k < 16; k++) writeCoef(4'(k), 16'h7FFF);
        for (int n = 0; n < 16; n++) applyStimulus(16'h7FFF, 1'b0, 16'h0, y, lat);
        checkOutput("sat_pos", 32'(y), 32'h7FFF);
        for (int n = 0; n < 16; n++) applyStimulus(16'h8000, 1'b0, 16'h0, y, lat);
        checkOutput("sat_neg", 32'(y), 32'h8000);

        // Overrun: second sample while busy is dropped
        doReset();
        writeCoef(4'd1, 16'h7FFF);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        pulses   = 0;
        last     = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == 3) begin
                checkOutput("ovr_busy_ready", 32'(in_ready), 32'd0);
                checkOutput("ovr_before", 32'(overrun), 32'd0);
                in_valid = 1'b1;
                in_data  = 16'h2000;
            end
            if (c == 4) checkOutput("ovr_set", 32'(overrun), 32'd1);
            if (out_valid) begin
                pulses++;
                last = out_data;
            end
        end
        checkOutput("ovr_pulses", 32'(pulses), 32'd1);
        checkOutput("ovr_data", 32'(last), 32'(16'h3FFF + RND));
        applyStimulus(16'h0000, 1'b0, 16'h0, y, lat);
        checkOutput("ovr_delay_line", 32'(y), 32'(16'h3FFF + RND));
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);

        // Reset during MAC aborts the computation
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_data", 32'(out_data), 32'd0);
        checkOutput("abort_overrun", 32'(overrun), 32'd0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        checkOutput("abort_no_pulse", 32'(pulses), 32'd0);
        applyStimulus(16'h4000, 1'b0, 16'h0, y, lat);
        checkOutput("abort_c0_reset", 32'(y), 32'(16'h3FFF + RND));
        applyStimulus(16'h0000, 1'b0, 16'h0, y, lat);
        checkOutput("abort_c1_reset", 32'(y), 32'h0000);

        // Coefficient write during MAC is ignored
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        lat      = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            coef_we   = (lat == 2);
            coef_addr = 4'd0;
            coef_data = 16'h0000;
        end while (!out_valid && lat < 100);
        coef_we = 1'b0;
        checkOutput("busy_we_latency", 32'(lat), 32'd17);
        checkOutput("busy_we_data", 32'(out_data), 32'(16'h3FFF + RND));
        applyStimulus(16'h4000, 1'b0, 16'h0, y, lat);
        checkOutput("busy_we_next", 32'(y), 32'(16'h3FFF + RND));

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
